// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed common-anode seven-segment scanner
// with guard blanking, per-digit blink and frame-boundary commit of new frames.
module seg_scan_driver #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 1000,
    parameter int GUARD        = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_data,
    input  logic [DIGITS-1:0]     load_dp,
    input  logic [DIGITS-1:0]     load_en,
    input  logic [DIGITS-1:0]     load_blink,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] GEND = PW'(GUARD);
    localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic [4*DIGITS-1:0] data;
        logic [DIGITS-1:0]   dp;
        logic [DIGITS-1:0]   en;
        logic [DIGITS-1:0]   blink;
    } frame_t;

    frame_t        act, pnd, ld;
    logic          pend, blink_phase, wrap, lit, blank;
    logic [PW-1:0] psc;
    logic [IW-1:0] idx;
    logic [FW-1:0] fcnt;
    logic [3:0]    nib;
    logic [6:0]    glyph;

    assign ld         = {load_data, load_dp, load_en, load_blink};
    assign load_ready = ~pend;
    assign wrap       = psc == PMAX && idx == IMAX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc         <= '0;
            idx         <= '0;
            fcnt        <= '0;
            blink_phase <= 1'b0;
            act         <= '0;
            pnd         <= '0;
            pend        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            psc        <= psc == PMAX ? '0 : psc + 1'b1;
            frame_done <= wrap;
            if (psc == PMAX)
                idx <= idx == IMAX ? '0 : idx + 1'b1;
            if (wrap) begin
                fcnt <= fcnt == FMAX ? '0 : fcnt + 1'b1;
                if (fcnt == FMAX)
                    blink_phase <= ~blink_phase;
            end
            // a transfer landing on the wrap with nothing pending bypasses straight to active
            if (wrap && (pend || load_valid)) begin
                act  <= pend ? pnd : ld;
                pend <= 1'b0;
            end else if (load_valid && !pend) begin
                pnd  <= ld;
                pend <= 1'b1;
            end
        end
    end

    assign nib   = act.data[{idx, 2'b00} +: 4];
    assign lit   = psc >= GEND && act.en[idx];
    assign blank = blink_phase && act.blink[idx];

    always_comb begin
        glyph = 7'h7F;
        case (nib)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
            default: glyph = 7'h7F;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out <= 8'hFF;
            dig_sel <= '1;
        end else begin
            seg_out <= lit && !blank ? {~act.dp[idx], glyph} : 8'hFF;
            dig_sel <= lit ? ~(DIGITS'(1) << idx) : '1;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized bench against a frame/slot-arithmetic reference model.
module tb_seg_scan_driver;
    localparam int D = 4, SD = 8, G = 2, BF = 2, FP = D * SD;
    localparam logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct packed {
        logic [4*D-1:0] d;
        logic [D-1:0]   dp;
        logic [D-1:0]   en;
        logic [D-1:0]   bl;
    } fr_t;

    logic           clk = 1'b0, rst_n = 1'b0, load_valid = 1'b0;
    logic [4*D-1:0] load_data = '0;
    logic [D-1:0]   load_dp = '0, load_en = '0, load_blink = '0;
    logic           load_ready, frame_done;
    logic [7:0]     seg_out;
    logic [D-1:0]   dig_sel;

    int     tests = 0, fails = 0;
    int     k;
    fr_t    act, pnd;
    bit     m_pend;
    logic [7:0]   exp_seg;
    logic [D-1:0] exp_dig;
    logic         exp_fd, exp_rdy;

    seg_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .GUARD(G), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_dp(load_dp), .load_en(load_en), .load_blink(load_blink),
        .seg_out(seg_out), .dig_sel(dig_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        k = 0;
        act = '0;
        pnd = '0;
        m_pend = 1'b0;
        exp_seg = 8'hFF;
        exp_dig = '1;
        exp_fd = 1'b0;
        exp_rdy = 1'b1;
    endtask

    // Expected outputs after each edge, from cycle index k since reset release.
    always @(posedge clk) if (rst_n) begin
        automatic int  slot = k % FP;
        automatic int  psc = k % SD;
        automatic int  dig = slot / SD;
        automatic bit  phase = ((k / FP) / BF) % 2 == 1;
        automatic bit  lit = psc >= G && act.en[dig];
        automatic fr_t inc = {load_data, load_dp, load_en, load_blink};
        exp_dig = lit ? ~(D'(1) << dig) : '1;
        exp_seg = (!lit || (phase && act.bl[dig])) ? 8'hFF : {~act.dp[dig], FONT[act.d[dig*4 +: 4]]};
        exp_fd  = slot == FP - 1;
        if (slot == FP - 1 && m_pend) begin
            act = pnd;
            m_pend = 1'b0;
        end else if (slot == FP - 1 && load_valid) begin
            act = inc;
        end else if (load_valid && !m_pend) begin
            pnd = inc;
            m_pend = 1'b1;
        end
        exp_rdy = !m_pend;
        k++;
    end

    always @(negedge clk) if (rst_n) begin
        chk("seg_out", seg_out, exp_seg);
        chk("dig_sel", dig_sel, exp_dig);
        chk("frame_done", frame_done, exp_fd);
        chk("load_ready", load_ready, exp_rdy);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic offer(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en, input logic [3:0] bl);
        load_data = d; load_dp = dp; load_en = en; load_blink = bl; load_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (load_ready) begin
                @(negedge clk);
                load_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        load_valid = 1'b0;
        chk("offer_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_slot(input int s);
        for (int i = 0; i < 2 * FP; i++) begin
            if (k % FP == s && !m_pend) return;
            @(negedge clk);
        end
        chk("wait_slot_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        model_reset();
        cycles(3);
        chk("rst_seg", seg_out, 8'hFF);
        chk("rst_dig", dig_sel, 4'hF);
        chk("rst_ready", load_ready, 1'b1);
        chk("rst_fd", frame_done, 1'b0);
        rst_n = 1'b1;
        cycles(3 * FP);
        // mid-frame load, shown only from the next frame
        cycles(10);
        offer(16'h3210, 4'h0, 4'hF, 4'h0);
        cycles(2 * FP);
        offer(16'hFBA8, 4'b0010, 4'hF, 4'h0);
        cycles(2 * FP);
        // back-to-back offers with valid held high
        offer(16'h4567, 4'h5, 4'hF, 4'h0);
        offer(16'h89CD, 4'hA, 4'hB, 4'h0);
        cycles(2 * FP);
        // transfer lands exactly on the wrap with nothing pending
        wait_slot(FP - 1);
        load_data = 16'hE1D2; load_dp = 4'h3; load_en = 4'hF; load_blink = 4'h0; load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        chk("bypass_ready", load_ready, 1'b1);
        cycles(2 * FP);
        offer(16'h7654, 4'h0, 4'hF, 4'b0010);
        cycles(5 * FP);
        for (int i = 0; i < 600; i++) begin
            load_valid = $urandom_range(0, 3) == 0;
            load_data = 16'($urandom);
            load_dp = 4'($urandom);
            load_en = 4'($urandom);
            load_blink = 4'($urandom);
            @(negedge clk);
        end
        load_valid = 1'b0;
        cycles(2 * FP);
        // async reset with a frame pending
        offer(16'h8888, 4'hF, 4'hF, 4'h0);
        cycles(FP);
        wait_slot(2);
        offer(16'h1234, 4'h0, 4'hF, 4'h0);
        cycles(SD + 1);
        chk("pre_rst_pending", load_ready, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_seg", seg_out, 8'hFF);
        chk("arst_dig", dig_sel, 4'hF);
        chk("arst_ready", load_ready, 1'b1);
        chk("arst_fd", frame_done, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2 * FP + 5);
        chk("post_rst_seg", seg_out, 8'hFF);
        chk("post_rst_dig", dig_sel, 4'hF);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
